// File: rtl/xras_action_enforcer.sv
// xras_action_enforcer: queued policy records drive one-hot enforcement outputs.
// Optional net-penalty ledger is built only when XRAS_ENF_LEDGER_EN is defined.
`timescale 1ns/1ps
module xras_action_enforcer #(
  parameter int FIFO_DEPTH      = 4,
  parameter int WARN_CYCLES     = 16,
  parameter int THROTTLE_CYCLES = 64,
  parameter int ISOLATE_CYCLES  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pol_valid,
  input  logic [7:0]  pol_action,
  input  logic [31:0] pol_penalty,
  input  logic [31:0] pol_credit,
  input  logic [31:0] pol_actor,
  input  logic        shutdown_clr,
  output logic        pol_ready,
  output logic        warn_o,
  output logic        throttle_o,
  output logic        isolate_o,
  output logic        shutdown_o,
  output logic [31:0] active_actor,
  output logic [31:0] ledger_balance,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_HOLD,
    S_SHUT
  } state_t;

  state_t state, state_d;

  logic [7:0]  act_q   [FIFO_DEPTH];
  logic [31:0] actor_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, empty;
  logic [7:0]    head_act;

  logic [7:0]  cur_act;
  logic [31:0] cur_actor;
  logic [31:0] timer, timer_d;
  logic        warn_d, thr_d, iso_d, shd_d;
  logic [31:0] actor_d;

  assign pol_ready = (count != FULL);
  assign empty     = (count == '0);
  assign push      = pol_valid & pol_ready;
  assign head_act  = act_q[rd_ptr];
  assign busy      = (state != S_IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (push) begin
      act_q[wr_ptr]   <= pol_action;
      actor_q[wr_ptr] <= pol_actor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)
        count <= count + CNT_ONE;
      else if (pop && !push)
        count <= count - CNT_ONE;
      if (pol_valid && !pol_ready && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    timer_d = timer;
    warn_d  = warn_o;
    thr_d   = throttle_o;
    iso_d   = isolate_o;
    shd_d   = shutdown_o;
    actor_d = active_actor;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        unique case (cur_act)
          8'd1: begin
            warn_d  = 1'b1;
            timer_d = 32'(WARN_CYCLES - 1);
            actor_d = cur_actor;
            state_d = S_HOLD;
          end
          8'd2: begin
            thr_d   = 1'b1;
            timer_d = 32'(THROTTLE_CYCLES - 1);
            actor_d = cur_actor;
            state_d = S_HOLD;
          end
          8'd3: begin
            iso_d   = 1'b1;
            timer_d = 32'(ISOLATE_CYCLES - 1);
            actor_d = cur_actor;
            state_d = S_HOLD;
          end
          8'd4: begin
            shd_d   = 1'b1;
            actor_d = cur_actor;
            state_d = S_SHUT;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_HOLD: begin
        // A strictly stronger head record preempts; the old output drops now.
        if (!empty && head_act > cur_act) begin
          pop     = 1'b1;
          warn_d  = 1'b0;
          thr_d   = 1'b0;
          iso_d   = 1'b0;
          actor_d = '0;
          state_d = S_APPLY;
        end else if (timer == '0) begin
          warn_d  = 1'b0;
          thr_d   = 1'b0;
          iso_d   = 1'b0;
          actor_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer - 32'd1;
        end
      end
      S_SHUT: begin
        if (shutdown_clr) begin
          shd_d   = 1'b0;
          actor_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      cur_act      <= '0;
      cur_actor    <= '0;
      warn_o       <= 1'b0;
      throttle_o   <= 1'b0;
      isolate_o    <= 1'b0;
      shutdown_o   <= 1'b0;
      active_actor <= '0;
    end else begin
      state        <= state_d;
      timer        <= timer_d;
      warn_o       <= warn_d;
      throttle_o   <= thr_d;
      isolate_o    <= iso_d;
      shutdown_o   <= shd_d;
      active_actor <= actor_d;
      if (pop) begin
        cur_act   <= head_act;
        cur_actor <= actor_q[rd_ptr];
      end
    end
  end

`ifdef XRAS_ENF_LEDGER_EN
  logic [31:0] pen_q  [FIFO_DEPTH];
  logic [31:0] cred_q [FIFO_DEPTH];
  logic [33:0] led_sum;
  logic [31:0] led_next;

  always_ff @(posedge clk) begin
    if (push) begin
      pen_q[wr_ptr]  <= pol_penalty;
      cred_q[wr_ptr] <= pol_credit;
    end
  end

  // 34-bit two's complement holds the full range; bit 33 flags a negative sum.
  assign led_sum = {2'b00, ledger_balance}
                 + {2'b00, pen_q[rd_ptr]}
                 - {2'b00, cred_q[rd_ptr]};

  always_comb begin
    led_next = led_sum[31:0];
    if (led_sum[33])
      led_next = '0;
    else if (led_sum[32])
      led_next = 32'hFFFF_FFFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ledger_balance <= '0;
    else if (pop)
      ledger_balance <= led_next;
  end
`else
  logic unused_ledger;
  assign unused_ledger  = ^{pol_penalty, pol_credit};
  assign ledger_balance = '0;
`endif

endmodule

// File: doc/xras_action_enforcer.md
XRAS_ACTION_ENFORCER -- requirements
Module: xras_action_enforcer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, policy record queue depth (power of two, 2..16).
REQ-002 The block SHALL have parameter WARN_CYCLES, default 16, warn hold time in clk cycles.
REQ-003 The block SHALL have parameter THROTTLE_CYCLES, default 64, throttle hold time in clk cycles.
REQ-004 The block SHALL have parameter ISOLATE_CYCLES, default 256, isolate hold time in clk cycles.
REQ-005 The block SHALL have these ports, one per line:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- pol_valid  input  1  one policy record per high cycle.
- pol_action  input  8  0 none, 1 warn, 2 throttle, 3 isolate, 4 shutdown.
- pol_penalty  input  32  penalty amount.
- pol_credit  input  32  credit amount.
- pol_actor  input  32  accountable actor ID.
- shutdown_clr  input  1  operator release of shutdown.
- pol_ready  output  1  queue not full.
- warn_o, throttle_o, isolate_o, shutdown_o  output  1 each  enforcement controls, one-hot or all zero.
- active_actor  output  32  actor of the action being enforced.
- ledger_balance  output  32  accumulated net penalty.
- drop_cnt  output  16  records lost to a full queue.
- busy  output  1  FSM not in IDLE or queue not empty.

Function
REQ-006 Push: a record SHALL be written when pol_valid=1 and pol_ready=1; pol_ready SHALL be 0 exactly when the queue holds FIFO_DEPTH entries.
REQ-007 Drop: pol_valid=1 with pol_ready=0 SHALL discard the record and increment drop_cnt, saturating at 16'hFFFF.
REQ-008 Push and pop in the same cycle SHALL leave the occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-009 FSM states SHALL be IDLE, APPLY, HOLD and SHUTDOWN.
REQ-010 IDLE: with the queue non-empty, the FSM SHALL pop the head record into the current-record registers and go to APPLY on the next cycle.
REQ-011 APPLY: for action 1/2/3, the FSM SHALL load the hold timer with WARN/THROTTLE/ISOLATE_CYCLES-1, assert the matching output and set active_actor on entry to HOLD.
REQ-012 APPLY: for action 4, the FSM SHALL assert shutdown_o and go to SHUTDOWN.
REQ-013 APPLY: action 0 or any value above 4 SHALL assert no output and return to IDLE.
REQ-014 HOLD: the timer SHALL decrement each cycle; at 0, the output SHALL deassert and the FSM SHALL go to IDLE, so the output is high for exactly N cycles.
REQ-015 Preemption: in HOLD, a queue head with action strictly greater than the current action SHALL be popped and go to APPLY on the next cycle; the current output SHALL drop in that same cycle.
REQ-016 Preemption SHALL NOT occur for equal or lower actions.
REQ-017 SHUTDOWN: shutdown_o SHALL stay 1 until shutdown_clr=1, then go to IDLE; the queue SHALL keep accepting records while in SHUTDOWN.
REQ-018 Ledger: on every pop, ledger_balance SHALL become balance + pol_penalty - pol_credit, computed in 34 bits and saturated to [0, 32'hFFFFFFFF].
REQ-019 Outputs SHALL be registered; the latency from push into an empty idle block to an asserted output SHALL be 3 cycles.

Reset
REQ-020 Reset SHALL empty the queue, set the FSM to IDLE and drive all outputs to 0.
REQ-021 Reset mid-HOLD or mid-SHUTDOWN SHALL drop enforcement immediately and asynchronously; queued records SHALL be lost.

Configuration
REQ-022 With XRAS_ENF_LEDGER_EN defined, the ledger SHALL behave as in REQ-018.
REQ-023 Without XRAS_ENF_LEDGER_EN, ledger_balance SHALL be constant 0 and no ledger registers or adders SHALL exist; all other behaviour SHALL be unchanged.

Verification
REQ-024 Push action=1, actor=0x0000_00A5: warn_o SHALL rise 3 cycles later, stay high exactly 16 cycles, and active_actor SHALL be 0xA5.
REQ-025 Action=2 then action=3 one cycle later: throttle_o SHALL assert, then isolate_o SHALL replace it with no overlap and stay high 256 cycles.
REQ-026 Action=4, then shutdown_clr pulse after 100 cycles: shutdown_o SHALL stay high until the clr cycle, then a queued action=1 SHALL be enforced.
REQ-027 Six back-to-back pushes into an empty block while it enforces an action-3 record: occupancy SHALL saturate at 4, pol_ready SHALL go 0, and drop_cnt SHALL count only the pushes made while full.
REQ-028 Ledger: penalty 1000 then credit 5000 SHALL give balance 1000 then 0; penalty 0xFFFFFFF0 twice SHALL saturate the balance at 0xFFFFFFFF.
REQ-029 Assert rst_n=0 mid-HOLD: all outputs SHALL be 0 without waiting for a clk edge, and busy SHALL be 0 after release.
